param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo_pkg.sv | 30 +++
 rtl/param_sync_fifo_mem.sv | 28 ++
 rtl/param_sync_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_pkg.sv
// Shared types and defaults for the parameterised synchronous FIFO.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package param_sync_fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;

    // Per-cycle operation actually performed, after acceptance checks.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WR    = 2'd1,
        OP_RD    = 2'd2,
        OP_WR_RD = 2'd3
    } fifo_op_e;

    function automatic fifo_op_e op_decode(input logic wr_acc, input logic rd_acc);
        fifo_op_e op;
        case ({rd_acc, wr_acc})
            2'b01:   op = OP_WR;
            2'b10:   op = OP_RD;
            2'b11:   op = OP_WR_RD;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read at i_rd_addr.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller only writes into free slots.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is never reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO, any depth 2..1024, with ack/overflow/underflow and occupancy flags.
// Latency: standard mode data_out one cycle after accepted read; FIFO_FWFT_EN shows head as soon as non-empty.
// Backpressure: full rejects writes (overflow) unless a read frees a slot that cycle; empty rejects reads (underflow).
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    // A depth of 2 still needs one address bit.
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    if (AF_LEVEL > FIFO_DEPTH || AE_LEVEL >= FIFO_DEPTH || FIFO_DEPTH < 2 ||
        FIFO_DEPTH > 1024 || FIFO_WIDTH < 1 || FIFO_WIDTH > 256) begin : g_bad_params
        $fatal(1, "param_sync_fifo: illegal parameter combination");
    end

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [FIFO_WIDTH-1:0] w_rd_dat;
    fifo_op_e              w_op;

    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    // A read frees the slot the write needs, so full plus read still accepts the write.
    assign w_rd_acc = rd_en && !w_empty;
    assign w_wr_acc = wr_en && (!w_full || w_rd_acc);
    assign w_op     = op_decode(w_wr_acc, w_rd_acc);

    // Occupancy update; a simultaneous read and write leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_WR:   w_count_nxt = r_count + 1'b1;
            OP_RD:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and one-cycle status pulses; pointers wrap by compare-and-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && !w_wr_acc;
            r_underflow <= rd_en && w_empty;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc && !rst),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_rd_dat)
    );

`ifdef FIFO_FWFT_EN
    logic [FIFO_WIDTH-1:0] r_last;

    // Remember the head shown each cycle so data_out keeps it once the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
        end else if (!w_empty) begin
            r_last <= w_rd_dat;
        end
    end

    assign data_out = w_empty ? r_last : w_rd_dat;
`else
    logic [FIFO_WIDTH-1:0] r_dout;

    // Output register loads the head only on an accepted read, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= w_rd_dat;
        end
    end

    assign data_out = r_dout;
`endif

    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= CNT_W'(AF_LEVEL));
    assign almostempty = (r_count <= CNT_W'(AE_LEVEL)) && !w_empty;
    assign count       = r_count;

endmodule
